// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment read-back path.
// Contents: active-low segment patterns {g,f,e,d,c,b,a} for hex 0..F,
// the blank pattern, and the scanner FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } scanState_t;

endpackage

// File: rtl/seg2hex_dec.sv
// Combinational 7-segment pattern decoder.
// Ports:
//   seg_data [6:0] in  : active-low segment pattern {g,f,e,d,c,b,a}
//   hex      [3:0] out : decoded value (0 unless is_hex)
//   is_hex         out : pattern is one of the 16 hex glyphs
//   is_blank       out : pattern is all segments dark
module seg2hex_dec
    import seg_pkg::*;
(
    input  logic [6:0] seg_data,
    output logic [3:0] hex,
    output logic       is_hex,
    output logic       is_blank
);

    // Pattern lookup; anything outside the table is neither hex nor blank.
    always_comb begin
        hex      = 4'h0;
        is_hex   = 1'b1;
        is_blank = 1'b0;
        case (seg_data)
            SEG_0:     hex = 4'h0;
            SEG_1:     hex = 4'h1;
            SEG_2:     hex = 4'h2;
            SEG_3:     hex = 4'h3;
            SEG_4:     hex = 4'h4;
            SEG_5:     hex = 4'h5;
            SEG_6:     hex = 4'h6;
            SEG_7:     hex = 4'h7;
            SEG_8:     hex = 4'h8;
            SEG_9:     hex = 4'h9;
            SEG_A:     hex = 4'hA;
            SEG_B:     hex = 4'hB;
            SEG_C:     hex = 4'hC;
            SEG_D:     hex = 4'hD;
            SEG_E:     hex = 4'hE;
            SEG_F:     hex = 4'hF;
            SEG_BLANK: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg2hex_scan.sv
// Multiplexed 7-segment bus scanner: samples the active-low segment bus and
// one-hot digit select, waits for STABLE_CYC identical samples, then commits
// the decoded value into that digit's slot.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   seg_data  [6:0]            : segment bus {g,f,e,d,c,b,a}, active-low
//   dig_sel   [DIGITS-1:0]     : one-hot digit select
//   hex_data  [4*DIGITS-1:0]   : decoded slot values, slot k at [4k+3:4k]
//   dig_valid [DIGITS-1:0]     : slot holds a valid hex value
//   upd                        : one-cycle pulse per hex/blank commit
//   err                        : one-cycle pulse per undecodable commit
//   err_cnt   [7:0]            : saturating err pulse count (only when
//                                SEG2HEX_ERR_CNT_EN is defined)
module seg2hex_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned STABLE_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_data,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   hex_data,
    output logic [DIGITS-1:0]     dig_valid,
    output logic                  upd,
    output logic                  err
`ifdef SEG2HEX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

    scanState_t        state, stateNext;
    logic [DIGITS-1:0] prevSel;
    logic [6:0]        prevSeg;
    logic [CNT_W-1:0]  stabCnt, stabCntNext, stabInc;
    logic              commit;
    logic              sameSample;
    logic [3:0]        decHex;
    logic              decIsHex, decIsBlank;

    seg2hex_dec uDec (
        .seg_data (seg_data),
        .hex      (decHex),
        .is_hex   (decIsHex),
        .is_blank (decIsBlank)
    );

    assign sameSample = (dig_sel == prevSel) && (seg_data == prevSeg);
    assign stabInc    = (stabCnt < CNT_MAX) ? stabCnt + CNT_W'(1) : stabCnt;

    // State, stability counter and last-sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            stabCnt <= '0;
            prevSel <= '0;
            prevSeg <= '0;
        end else begin
            state   <= stateNext;
            stabCnt <= stabCntNext;
            prevSel <= dig_sel;
            prevSeg <= seg_data;
        end
    end

    // Next state and commit decision; a new run always restarts at count 1.
    always_comb begin
        stateNext   = state;
        stabCntNext = stabCnt;
        commit      = 1'b0;
        if (!$onehot(dig_sel)) begin
            stateNext   = IDLE;
            stabCntNext = '0;
        end else if (state == IDLE || !sameSample) begin
            stabCntNext = CNT_W'(1);
            if (STABLE_CYC == 1) begin
                commit    = 1'b1;
                stateNext = HELD;
            end else begin
                stateNext = TRACK;
            end
        end else if (state == TRACK) begin
            stabCntNext = stabInc;
            if (stabInc == CNT_MAX) begin
                commit    = 1'b1;
                stateNext = HELD;
            end
        end
    end

    // Slot registers and result pulses; only the selected slot is touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_data  <= '0;
            dig_valid <= '0;
            upd       <= 1'b0;
            err       <= 1'b0;
        end else begin
            upd <= 1'b0;
            err <= 1'b0;
            if (commit) begin
                if (decIsHex || decIsBlank) begin
                    upd <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
                for (int k = 0; k < DIGITS; k++) begin
                    if (dig_sel[k]) begin
                        if (decIsHex) begin
                            hex_data[4*k +: 4] <= decHex;
                            dig_valid[k]       <= 1'b1;
                        end else if (decIsBlank) begin
                            hex_data[4*k +: 4] <= 4'h0;
                            dig_valid[k]       <= 1'b0;
                        end else begin
                            dig_valid[k]       <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef SEG2HEX_ERR_CNT_EN
    // Saturating count of decode errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg2hex_scan.sv
// Scoreboard bench for seg2hex_scan (DIGITS=4, STABLE_CYC=3).
module tb_seg2hex_scan;

    typedef struct packed {
        logic [1:0]  pls;   // {upd,err}
        logic [15:0] hex;
        logic [3:0]  valid;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  segData;
    logic [3:0]  digSel;
    logic [15:0] hexData;
    logic [3:0]  digValid;
    logic        upd;
    logic        err;
`ifdef SEG2HEX_ERR_CNT_EN
    logic [7:0]  errCnt;
`endif

    exp_t        expQ[$];
    logic [31:0] cyc;
    int          total;
    int          bad;

    seg2hex_scan #(.DIGITS(4), .STABLE_CYC(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_data  (segData),
        .dig_sel   (digSel),
        .hex_data  (hexData),
        .dig_valid (digValid),
        .upd       (upd),
        .err       (err)
`ifdef SEG2HEX_ERR_CNT_EN
        ,
        .err_cnt   (errCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (upd || err)) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got upd=%b err=%b hex=%h valid=%b at cyc %0d, want no pulse",
                         upd, err, hexData, digValid, cyc);
            end else begin
                e = expQ.pop_front();
                if ({upd, err} != e.pls || hexData != e.hex || digValid != e.valid || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL commit: got upd/err=%b hex=%h valid=%b cyc=%0d, want upd/err=%b hex=%h valid=%b cyc=%0d",
                             {upd, err}, hexData, digValid, cyc, e.pls, e.hex, e.valid, e.cyc);
                end
            end
        end
    end

    // Apply one input pair for n cycles; optionally expect a commit after 3 samples.
    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n,
                        input logic [1:0] pls, input logic [15:0] h, input logic [3:0] v);
        exp_t e;
        digSel  = sel;
        segData = seg;
        if (pls != 2'b00) begin
            e.pls   = pls;
            e.hex   = h;
            e.valid = v;
            e.cyc   = cyc + 32'd3;
            expQ.push_back(e);
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOut(input string name, input logic [15:0] h, input logic [3:0] v,
                            input logic [7:0] ec);
        logic [7:0] ecGot;
`ifdef SEG2HEX_ERR_CNT_EN
        ecGot = errCnt;
`else
        ecGot = ec;
`endif
        total++;
        if (hexData != h || digValid != v || upd || err || ecGot != ec) begin
            bad++;
            $display("FAIL %s: got hex=%h valid=%b upd=%b err=%b errcnt=%0d, want hex=%h valid=%b upd=0 err=0 errcnt=%0d",
                     name, hexData, digValid, upd, err, ecGot, h, v, ec);
        end
    endtask

    logic [6:0] pats [16];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        total   = 0;
        bad     = 0;
        cyc     = 32'd0;
        rst_n   = 1'b0;
        digSel  = 4'b0000;
        segData = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        checkOut("reset_state", 16'h0000, 4'b0000, 8'd0);
        rst_n = 1'b1;

        // Every glyph in slot 1.
        for (int i = 0; i < 16; i++)
            hold(4'b0010, pats[i], 3, 2'b10, 16'(i) << 4, 4'b0010);
        // Blank clears the slot.
        hold(4'b0010, 7'h7F, 3, 2'b10, 16'h0000, 4'b0000);

        // Two four-digit frames; second frame recommits identical values.
        for (int f = 0; f < 2; f++) begin
            hold(4'b0001, 7'h40, 4, 2'b10, 16'h0000 | (f != 0 ? 16'h3210 : 16'h0000), f != 0 ? 4'b1111 : 4'b0001);
            hold(4'b0010, 7'h79, 4, 2'b10, f != 0 ? 16'h3210 : 16'h0010, f != 0 ? 4'b1111 : 4'b0011);
            hold(4'b0100, 7'h24, 4, 2'b10, f != 0 ? 16'h3210 : 16'h0210, f != 0 ? 4'b1111 : 4'b0111);
            hold(4'b1000, 7'h30, 4, 2'b10, 16'h3210, 4'b1111);
        end

        // Short run of 2 is discarded; following 3-cycle run commits.
        hold(4'b0001, 7'h24, 2, 2'b00, 16'h0, 4'h0);
        hold(4'b0001, 7'h30, 3, 2'b10, 16'h3213, 4'b1111);

        // "A" in slot 2, then an invalid pattern keeps the value but drops valid.
        hold(4'b0100, 7'h08, 3, 2'b10, 16'h3A13, 4'b1111);
        hold(4'b0100, 7'h55, 3, 2'b01, 16'h3A13, 4'b1011);
        hold(4'b0100, 7'h55, 1, 2'b00, 16'h0, 4'h0);
        checkOut("after_err", 16'h3A13, 4'b1011, 8'd1);

        // Non-one-hot selects never commit.
        hold(4'b0101, 7'h00, 10, 2'b00, 16'h0, 4'h0);
        hold(4'b0000, 7'h40, 10, 2'b00, 16'h0, 4'h0);
        checkOut("no_onehot", 16'h3A13, 4'b1011, 8'd1);

        // Long hold commits once.
        hold(4'b1000, 7'h79, 12, 2'b10, 16'h1A13, 4'b1011);
        checkOut("long_hold", 16'h1A13, 4'b1011, 8'd1);

        // Reset after two stable samples, then a fresh full count.
        hold(4'b0010, 7'h12, 2, 2'b00, 16'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOut("async_reset", 16'h0000, 4'b0000, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b0010, 7'h12, 3, 2'b10, 16'h0050, 4'b0010);

        hold(4'b0000, 7'h7F, 5, 2'b00, 16'h0, 4'h0);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL missing_pulse: got %0d commits outstanding, want 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
